// File: rtl/microwave_time_entry_countdown_if.sv
// Keypad/control inputs and time/status outputs of the microwave time-entry countdown.
// The master drives the keypad and control levels, and the slave (the countdown) drives the display and status.
interface microwave_time_entry_countdown_if;
   // key_valid is a level held for as long as a key is down; digit is
   // meaningful while key_valid is high. There is no ready: the consumer
   // accepts one press on the rising edge of key_valid and never stalls.
   logic [3:0] digit;
   logic       key_valid;
   logic       start;
   logic       stop_clear;
   logic       door_closed;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       magnetron_on;
   logic       done;
   logic [2:0] state_out;

   modport master (
      output digit, key_valid, start, stop_clear, door_closed,
      input  min_tens, min_ones, sec_tens, sec_ones, magnetron_on, done, state_out
   );

   modport slave (
      input  digit, key_valid, start, stop_clear, door_closed,
      output min_tens, min_ones, sec_tens, sec_ones, magnetron_on, done, state_out
   );
endinterface

// File: rtl/microwave_time_entry_countdown.sv
// MM:SS BCD time entry from keypad digits, then a once-per-second countdown
// that drives magnetron enable and done.
module microwave_time_entry_countdown #(
   parameter int CLK_PER_SEC = 1000
) (
   input logic clk,
   input logic rst,
   microwave_time_entry_countdown_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SET   = 3'd1,
      RUN   = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int DW = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_PER_SEC - 1);

   state_t        state;
   logic [DW-1:0] div;
   logic          key_valid_q;
   logic [3:0]    mt, mo, st, so;
   logic          magnetron_on_r, done_r;

   logic       key_accept;
   logic       time_zero, time_one, tick;
   logic [3:0] dec_mt, dec_mo, dec_st, dec_so;

   // Rising edge of key_valid only, so a held key shifts in one digit.
   assign key_accept = bus.key_valid & ~key_valid_q & (bus.digit <= 4'd9);
   assign time_zero  = (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd0);
   assign time_one   = (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd1);
   assign tick       = (state == RUN) && (div == DIV_LAST);

   // Seconds tens may hold 6..9 from entry, so only a borrow reloads it to 5.
   always_comb begin
      dec_mt = mt;
      dec_mo = mo;
      dec_st = st;
      dec_so = so;
      if (so != 4'd0) begin
         dec_so = so - 4'd1;
      end else begin
         dec_so = 4'd9;
         if (st != 4'd0) begin
            dec_st = st - 4'd1;
         end else begin
            dec_st = 4'd5;
            if (mo != 4'd0) begin
               dec_mo = mo - 4'd1;
            end else begin
               dec_mo = 4'd9;
               dec_mt = mt - 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         div            <= '0;
         key_valid_q    <= 1'b0;
         mt             <= 4'd0;
         mo             <= 4'd0;
         st             <= 4'd0;
         so             <= 4'd0;
         magnetron_on_r <= 1'b0;
         done_r         <= 1'b0;
      end else begin
         key_valid_q <= bus.key_valid;
         div         <= '0;
         case (state)
            IDLE: begin
               if (bus.stop_clear) begin
                  mt <= 4'd0;
                  mo <= 4'd0;
                  st <= 4'd0;
                  so <= 4'd0;
               end else if (bus.start) begin
                  state <= IDLE;
               end else if (key_accept) begin
                  mt    <= mo;
                  mo    <= st;
                  st    <= so;
                  so    <= bus.digit;
                  state <= SET;
               end
            end

            SET: begin
               if (bus.stop_clear) begin
                  mt    <= 4'd0;
                  mo    <= 4'd0;
                  st    <= 4'd0;
                  so    <= 4'd0;
                  state <= IDLE;
               end else if (bus.start) begin
                  if (bus.door_closed && !time_zero) begin
                     state          <= RUN;
                     magnetron_on_r <= 1'b1;
                  end
               end else if (key_accept) begin
                  mt <= mo;
                  mo <= st;
                  st <= so;
                  so <= bus.digit;
               end
            end

            RUN: begin
               // An open door beats a coincident tick: no decrement on the way out.
               if (!bus.door_closed || bus.stop_clear) begin
                  state          <= PAUSE;
                  magnetron_on_r <= 1'b0;
               end else if (tick) begin
                  mt <= dec_mt;
                  mo <= dec_mo;
                  st <= dec_st;
                  so <= dec_so;
                  if (time_one) begin
                     state          <= DONE;
                     magnetron_on_r <= 1'b0;
                     done_r         <= 1'b1;
                  end
               end else begin
                  div <= div + DW'(1);
               end
            end

            PAUSE: begin
               if (bus.stop_clear) begin
                  mt    <= 4'd0;
                  mo    <= 4'd0;
                  st    <= 4'd0;
                  so    <= 4'd0;
                  state <= IDLE;
               end else if (bus.start && bus.door_closed) begin
                  state          <= RUN;
                  magnetron_on_r <= 1'b1;
               end
            end

            DONE: begin
               mt <= 4'd0;
               mo <= 4'd0;
               st <= 4'd0;
               so <= 4'd0;
               if (bus.stop_clear || bus.start || key_accept) begin
                  state  <= IDLE;
                  done_r <= 1'b0;
               end
            end

            default: begin
               state          <= IDLE;
               magnetron_on_r <= 1'b0;
               done_r         <= 1'b0;
            end
         endcase
      end
   end

   assign bus.min_tens     = mt;
   assign bus.min_ones     = mo;
   assign bus.sec_tens     = st;
   assign bus.sec_ones     = so;
   assign bus.magnetron_on = magnetron_on_r;
   assign bus.done         = done_r;
   assign bus.state_out    = state;

endmodule

// File: tb/tb_microwave_time_entry_countdown.sv
// Directed bench for the microwave countdown with CLK_PER_SEC=4; inputs change
// and outputs are sampled on the falling clock edge.
module tb_microwave_time_entry_countdown;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   logic [15:0] exp_q[$];

   microwave_time_entry_countdown_if bus ();

   microwave_time_entry_countdown #(.CLK_PER_SEC(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] dig();
      return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- drivers (called at a falling edge) ----------------
   task automatic press(input logic [3:0] d);
      bus.digit     = d;
      bus.key_valid = 1'b1;
      @(negedge clk);
      bus.key_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic pulse_clear();
      bus.stop_clear = 1'b1;
      @(negedge clk);
      bus.stop_clear = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      checks++;
      if (dig() !== 16'h0000) begin
         errors++; $display("FAIL reset_digits: got %h expected 0000", dig());
      end
      checks++;
      if (bus.state_out !== 3'd0) begin
         errors++; $display("FAIL reset_state: got %0d expected 0", bus.state_out);
      end
      checks++;
      if (bus.magnetron_on !== 1'b0 || bus.done !== 1'b0) begin
         errors++; $display("FAIL reset_flags: got mag=%b done=%b expected 0 0", bus.magnetron_on, bus.done);
      end
   endtask

   task automatic test_entry();
      do_reset();
      press(4'd1);
      checks++;
      if (bus.state_out !== 3'd1) begin
         errors++; $display("FAIL entry_to_set: got %0d expected 1", bus.state_out);
      end
      press(4'd3);
      press(4'd0);
      checks++;
      if (dig() !== 16'h0130) begin
         errors++; $display("FAIL entry_130: got %h expected 0130", dig());
      end
      // Held key: one shift only.
      bus.digit     = 4'd5;
      bus.key_valid = 1'b1;
      repeat (10) @(negedge clk);
      bus.key_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (dig() !== 16'h1305) begin
         errors++; $display("FAIL entry_held: got %h expected 1305", dig());
      end
      press(4'd12);
      checks++;
      if (dig() !== 16'h1305) begin
         errors++; $display("FAIL entry_invalid_digit: got %h expected 1305", dig());
      end
      press(4'd7);
      checks++;
      if (dig() !== 16'h3057) begin
         errors++; $display("FAIL entry_discard_top: got %h expected 3057", dig());
      end
   endtask

   task automatic test_countdown_done();
      do_reset();
      bus.door_closed = 1'b1;
      press(4'd0);
      press(4'd2);
      pulse_start();
      checks++;
      if (bus.state_out !== 3'd2 || bus.magnetron_on !== 1'b1) begin
         errors++; $display("FAIL run_entry: got state=%0d mag=%b expected 2 1", bus.state_out, bus.magnetron_on);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (dig() !== 16'h0002) begin
         errors++; $display("FAIL run_before_tick: got %h expected 0002", dig());
      end
      @(negedge clk);
      checks++;
      if (dig() !== 16'h0001) begin
         errors++; $display("FAIL run_first_tick: got %h expected 0001", dig());
      end
      repeat (4) @(negedge clk);
      checks++;
      if (dig() !== 16'h0000 || bus.state_out !== 3'd4) begin
         errors++; $display("FAIL run_to_done: got %h state=%0d expected 0000 state=4", dig(), bus.state_out);
      end
      checks++;
      if (bus.done !== 1'b1 || bus.magnetron_on !== 1'b0) begin
         errors++; $display("FAIL done_flags: got done=%b mag=%b expected 1 0", bus.done, bus.magnetron_on);
      end
      press(4'd7);
      checks++;
      if (bus.state_out !== 3'd0 || dig() !== 16'h0000 || bus.done !== 1'b0) begin
         errors++; $display("FAIL done_key_exit: got state=%0d %h done=%b expected 0 0000 0", bus.state_out, dig(), bus.done);
      end
   endtask

   task automatic test_borrow();
      do_reset();
      bus.door_closed = 1'b1;
      press(4'd1);
      press(4'd0);
      press(4'd0);
      pulse_start();
      repeat (4) @(negedge clk);
      checks++;
      if (dig() !== 16'h0059) begin
         errors++; $display("FAIL borrow_100: got %h expected 0059", dig());
      end
      pulse_clear();
      checks++;
      if (bus.state_out !== 3'd3) begin
         errors++; $display("FAIL clear_in_run_pauses: got %0d expected 3", bus.state_out);
      end
      pulse_clear();
      checks++;
      if (bus.state_out !== 3'd0 || dig() !== 16'h0000) begin
         errors++; $display("FAIL clear_in_pause: got state=%0d %h expected 0 0000", bus.state_out, dig());
      end
      press(4'd9);
      press(4'd9);
      exp_q = {16'h0098, 16'h0097, 16'h0096, 16'h0095, 16'h0094,
               16'h0093, 16'h0092, 16'h0091, 16'h0090, 16'h0089};
      pulse_start();
      for (int i = 0; i < 10; i++) begin
         logic [15:0] e;
         repeat (4) @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (dig() !== e) begin
            errors++; $display("FAIL tick_099 #%0d: got %h expected %h", i + 1, dig(), e);
         end
      end
      pulse_clear();
      pulse_clear();
   endtask

   task automatic test_pause_resume();
      do_reset();
      bus.door_closed = 1'b1;
      press(4'd5);
      pulse_start();
      repeat (3) @(negedge clk);
      bus.door_closed = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.state_out !== 3'd3 || dig() !== 16'h0005 || bus.magnetron_on !== 1'b0) begin
         errors++; $display("FAIL door_open_with_tick: got state=%0d %h mag=%b expected 3 0005 0", bus.state_out, dig(), bus.magnetron_on);
      end
      pulse_start();
      checks++;
      if (bus.state_out !== 3'd3) begin
         errors++; $display("FAIL start_door_open_pause: got %0d expected 3", bus.state_out);
      end
      press(4'd7);
      checks++;
      if (dig() !== 16'h0005) begin
         errors++; $display("FAIL key_in_pause: got %h expected 0005", dig());
      end
      bus.door_closed = 1'b1;
      pulse_start();
      checks++;
      if (bus.state_out !== 3'd2) begin
         errors++; $display("FAIL resume: got %0d expected 2", bus.state_out);
      end
      press(4'd8);
      @(negedge clk);
      checks++;
      if (dig() !== 16'h0005) begin
         errors++; $display("FAIL key_in_run_no_early_tick: got %h expected 0005", dig());
      end
      @(negedge clk);
      checks++;
      if (dig() !== 16'h0004) begin
         errors++; $display("FAIL resume_tick: got %h expected 0004", dig());
      end
   endtask

   task automatic test_set_start_block();
      do_reset();
      press(4'd1);
      press(4'd2);
      press(4'd3);
      press(4'd4);
      bus.door_closed = 1'b0;
      pulse_start();
      checks++;
      if (bus.state_out !== 3'd1 || dig() !== 16'h1234) begin
         errors++; $display("FAIL start_door_open_set: got state=%0d %h expected 1 1234", bus.state_out, dig());
      end
      bus.door_closed = 1'b1;
      pulse_clear();
      checks++;
      if (bus.state_out !== 3'd0 || dig() !== 16'h0000) begin
         errors++; $display("FAIL clear_in_set: got state=%0d %h expected 0 0000", bus.state_out, dig());
      end
      press(4'd0);
      pulse_start();
      checks++;
      if (bus.state_out !== 3'd1 || bus.magnetron_on !== 1'b0) begin
         errors++; $display("FAIL start_time_zero: got state=%0d mag=%b expected 1 0", bus.state_out, bus.magnetron_on);
      end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      bus.door_closed = 1'b1;
      press(4'd3);
      pulse_start();
      @(negedge clk);
      rst = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      checks++;
      if (dig() !== 16'h0000 || bus.state_out !== 3'd0 || bus.magnetron_on !== 1'b0) begin
         errors++; $display("FAIL reset_mid_run: got %h state=%0d mag=%b expected 0000 0 0", dig(), bus.state_out, bus.magnetron_on);
      end
      rst = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      errors         = 0;
      checks         = 0;
      rst            = 1'b1;
      bus.digit      = 4'd0;
      bus.key_valid  = 1'b0;
      bus.start      = 1'b0;
      bus.stop_clear = 1'b0;
      bus.door_closed = 1'b0;
      @(negedge clk);
      test_reset();
      test_entry();
      test_countdown_done();
      test_borrow();
      test_pause_resume();
      test_set_start_block();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
